// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, scoreboard entry layout and select/avail helpers for hazard_scoreboard.
// Register count and tracked depth are fixed here so every file agrees on AW/SW.
package hazard_scoreboard_pkg;

  localparam int NREG   = 16;
  localparam int NSTAGE = 3;
  localparam int AW     = $clog2(NREG);
  localparam int SW     = $clog2(NSTAGE);

  localparam logic [SW-1:0] AVAIL_MAX = SW'(NSTAGE - 2);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] dst;
    logic [SW-1:0] avail;
  } sb_entry_t;

  // Results can never be later than the last bypassable position.
  function automatic logic [SW-1:0] clamp_avail(input logic [SW-1:0] a);
    return (a > AVAIL_MAX) ? AVAIL_MAX : a;
  endfunction

  // The producer moves one position before the consumer reaches EX, hence k+1.
  function automatic logic [SW-1:0] byp_sel(input logic found, input logic [SW-1:0] k);
    if (found && ((int'(k) + 1) < NSTAGE)) begin
      return SW'(int'(k) + 1);
    end else begin
      return {SW{1'b0}};
    end
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Youngest-match priority encoder: finds the closest in-flight writer of one
// operand register and reports whether its result is still unavailable.
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int ZERO_REG = 0
) (
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  sb_entry_t     i_entries [NSTAGE],
  output logic          o_found,
  output logic [SW-1:0] o_k,
  output logic          o_hazard
);

  logic w_addr_ok;
  logic w_hit;

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    o_found   = 1'b0;
    o_k       = {SW{1'b0}};
    o_hazard  = 1'b0;
    w_hit     = 1'b0;
    w_addr_ok = i_re & ~((ZERO_REG != 0) && (i_addr == {AW{1'b0}}));
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      w_hit    = w_addr_ok & i_entries[k].v & (i_entries[k].dst == i_addr);
      o_found  = o_found | w_hit;
      o_k      = w_hit ? SW'(k) : o_k;
      o_hazard = w_hit ? (i_entries[k].avail > SW'(k)) : o_hazard;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-side hazard scoreboard: tracks in-flight writes, raises the ID stall and
// produces registered EX bypass selects plus a saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ZERO_REG = 0,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_id_valid,
  input  logic            i_rf_re0,
  input  logic            i_rf_re1,
  input  logic [AW-1:0]   i_rf_p0_addr,
  input  logic [AW-1:0]   i_rf_p1_addr,
  input  logic            i_rf_we,
  input  logic [AW-1:0]   i_rf_dst_addr,
  input  logic [SW-1:0]   i_avail,
  input  logic            i_flush,
  input  logic            i_kill_ex,
  input  logic            i_freeze,
  output logic            o_stall_id,
  output logic [SW-1:0]   o_byp0_sel,
  output logic [SW-1:0]   o_byp1_sel,
  output logic [CNTW-1:0] o_stall_cnt
);

  logic [NSTAGE-1:0] r_v;
  logic [AW-1:0]     r_dst   [NSTAGE];
  logic [SW-1:0]     r_avail [NSTAGE];
  logic [SW-1:0]     r_byp0_sel;
  logic [SW-1:0]     r_byp1_sel;
  logic [CNTW-1:0]   r_stall_cnt;

  sb_entry_t     w_entries [NSTAGE];
  logic          w_found0, w_found1;
  logic [SW-1:0] w_k0, w_k1;
  logic          w_haz0, w_haz1;
  logic          w_stall;
  logic          w_issue;
  logic [SW-1:0] w_sel0, w_sel1;

  // Pack the split state arrays into entry structs for the matchers.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      w_entries[k] = '{v: r_v[k], dst: r_dst[k], avail: r_avail[k]};
    end
  end

  sb_match #(.ZERO_REG(ZERO_REG)) u_match0 (
    .i_re      (i_rf_re0),
    .i_addr    (i_rf_p0_addr),
    .i_entries (w_entries),
    .o_found   (w_found0),
    .o_k       (w_k0),
    .o_hazard  (w_haz0)
  );

  sb_match #(.ZERO_REG(ZERO_REG)) u_match1 (
    .i_re      (i_rf_re1),
    .i_addr    (i_rf_p1_addr),
    .i_entries (w_entries),
    .o_found   (w_found1),
    .o_k       (w_k1),
    .o_hazard  (w_haz1)
  );

  // Flush overrides the stall; only an issuing instruction gets bypass selects.
  always_comb begin
    w_stall = i_id_valid & ~i_flush & (w_haz0 | w_haz1);
    w_issue = i_id_valid & ~i_flush & ~w_stall;
    w_sel0  = w_issue ? byp_sel(w_found0, w_k0) : {SW{1'b0}};
    w_sel1  = w_issue ? byp_sel(w_found1, w_k1) : {SW{1'b0}};
  end

  // Valid bits shift down the pipe; kill_ex knocks out the producer leaving EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= {NSTAGE{1'b0}};
    end else if (!i_freeze) begin
      r_v[0] <= w_issue & i_rf_we;
      r_v[1] <= r_v[0] & ~i_kill_ex;
      for (int k = 2; k < NSTAGE; k++) begin
        r_v[k] <= r_v[k-1];
      end
    end
  end

  // Payload needs no reset: it is only looked at behind a set valid bit.
  always_ff @(posedge clk) begin
    if (!i_freeze) begin
      r_dst[0]   <= i_rf_dst_addr;
      r_avail[0] <= clamp_avail(i_avail);
      for (int k = 1; k < NSTAGE; k++) begin
        r_dst[k]   <= r_dst[k-1];
        r_avail[k] <= r_avail[k-1];
      end
    end
  end

  // Registered bypass selects and the saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp0_sel  <= {SW{1'b0}};
      r_byp1_sel  <= {SW{1'b0}};
      r_stall_cnt <= {CNTW{1'b0}};
    end else if (!i_freeze) begin
      r_byp0_sel <= w_sel0;
      r_byp1_sel <= w_sel1;
      if (w_stall && (r_stall_cnt != {CNTW{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
    end
  end

  assign o_stall_id  = w_stall;
  assign o_byp0_sel  = r_byp0_sel;
  assign o_byp1_sel  = r_byp1_sel;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-step expected outputs are queued
// as stimulus is driven and compared once the clock edge has produced them.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_id_valid = 1'b0, i_rf_re0 = 1'b0, i_rf_re1 = 1'b0;
  logic [AW-1:0]   i_rf_p0_addr = '0, i_rf_p1_addr = '0, i_rf_dst_addr = '0;
  logic            i_rf_we = 1'b0;
  logic [SW-1:0]   i_avail = '0;
  logic            i_flush = 1'b0, i_kill_ex = 1'b0, i_freeze = 1'b0;
  logic            o_stall_id;
  logic [SW-1:0]   o_byp0_sel, o_byp1_sel;
  logic [15:0]     o_stall_cnt;

  typedef struct { int s0; int s1; int cnt; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;

  hazard_scoreboard #(.ZERO_REG(1), .CNTW(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_id_valid    (i_id_valid),
    .i_rf_re0      (i_rf_re0),
    .i_rf_re1      (i_rf_re1),
    .i_rf_p0_addr  (i_rf_p0_addr),
    .i_rf_p1_addr  (i_rf_p1_addr),
    .i_rf_we       (i_rf_we),
    .i_rf_dst_addr (i_rf_dst_addr),
    .i_avail       (i_avail),
    .i_flush       (i_flush),
    .i_kill_ex     (i_kill_ex),
    .i_freeze      (i_freeze),
    .o_stall_id    (o_stall_id),
    .o_byp0_sel    (o_byp0_sel),
    .o_byp1_sel    (o_byp1_sel),
    .o_stall_cnt   (o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One ID cycle: drive, check the combinational stall, queue and then compare registered outputs.
  task automatic step(input string tag, input int v, input int re0, input int a0,
                      input int re1, input int a1, input int we, input int d, input int av,
                      input int fl, input int kl, input int fz,
                      input int est, input int es0, input int es1);
    exp_t e;
    @(negedge clk);
    i_id_valid    = (v != 0);
    i_rf_re0      = (re0 != 0);
    i_rf_p0_addr  = AW'(a0);
    i_rf_re1      = (re1 != 0);
    i_rf_p1_addr  = AW'(a1);
    i_rf_we       = (we != 0);
    i_rf_dst_addr = AW'(d);
    i_avail       = SW'(av);
    i_flush       = (fl != 0);
    i_kill_ex     = (kl != 0);
    i_freeze      = (fz != 0);
    #1;
    check_eq({tag, ".stall"}, 32'(o_stall_id), est);
    if (est != 0 && fz == 0) m_cnt++;
    e.s0 = es0; e.s1 = es1; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, ".sel0"}, 32'(o_byp0_sel), e.s0);
      check_eq({tag, ".sel1"}, 32'(o_byp1_sel), e.s1);
      check_eq({tag, ".cnt"},  32'(o_stall_cnt), e.cnt);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset.stall", 32'(o_stall_id), 0);
    check_eq("reset.sel0",  32'(o_byp0_sel), 0);
    check_eq("reset.sel1",  32'(o_byp1_sel), 0);
    check_eq("reset.cnt",   32'(o_stall_cnt), 0);
    rst = 1'b0;

    //    tag       v re0 a0 re1 a1 we d av fl kl fz est s0 s1
    step("alu_p",   1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step("alu_c",   1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("gap_p",   1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step("gap_g",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("gap_c",   1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step("gap2_c",  1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("ld_p",    1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step("ld_c",    1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("ld_c2",   1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("y_p1",    1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step("y_p2",    1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step("y_c",     1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("cl_p",    1, 0, 0, 0, 0, 1, 6, 3, 0, 0, 0, 0, 0, 0);
    step("cl_c",    1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("cl_c2",   1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step("z_p",     1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step("z_c",     1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("f_p",     1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step("f_c",     1, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("f_c2",    1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("k_p",     1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    step("k_c",     1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("k_c2",    1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("fz_a",    1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    step("fz_b",    1, 1, 4, 0, 0, 1, 9, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("fz_h",  1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    end
    step("fz_c",    1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("fz_c2",   1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("r_a",     1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    step("r_b",     1, 1, 4, 0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 0);

    // Load-use stall in progress, then reset lands between edges.
    @(negedge clk);
    i_id_valid = 1'b1; i_rf_re0 = 1'b0; i_rf_re1 = 1'b1; i_rf_p1_addr = AW'(5);
    i_rf_we = 1'b0; i_flush = 1'b0; i_kill_ex = 1'b0; i_freeze = 1'b0;
    #1;
    check_eq("rst_pre.stall", 32'(o_stall_id), 1);
    check_eq("rst_pre.sel0",  32'(o_byp0_sel), 1);
    check_eq("rst_pre.cnt",   32'(o_stall_cnt), m_cnt);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid.stall", 32'(o_stall_id), 0);
    check_eq("rst_mid.sel0",  32'(o_byp0_sel), 0);
    check_eq("rst_mid.sel1",  32'(o_byp1_sel), 0);
    check_eq("rst_mid.cnt",   32'(o_stall_cnt), 0);
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 0;

    step("post_p",  1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    step("post_c",  1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("post_c2", 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step("post_b",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
